// File: rtl/lab1_imul_mul_arbiter_pkg.sv
// Shared types and widths for the multiplier arbiter: FSM encoding and
// request/response message sizes.
package lab1_imul_mul_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_e;

  localparam int REQ_NBITS  = 64;
  localparam int RESP_NBITS = 32;

endpackage

// File: rtl/lab1_imul_rr_grant.sv
// Combinational round-robin grant: picks the first asserted request at or
// after prio_ptr, wrapping modulo p_nreqs.
module lab1_imul_rr_grant #(
  parameter  int p_nreqs     = 4,
  localparam int p_idx_nbits = $clog2(p_nreqs)
) (
  input  logic [p_nreqs-1:0]      reqs,
  input  logic [p_idx_nbits-1:0]  prio_ptr,
  output logic [p_idx_nbits-1:0]  gnt_idx,
  output logic                    any_req
);

  localparam int SW = p_idx_nbits + 1;

  logic [p_idx_nbits-1:0] cand_idx [p_nreqs];
  logic [p_nreqs-1:0]     cand_val;

  // cand_idx[gi] is the port visited gi steps after the pointer
  for (genvar gi = 0; gi < p_nreqs; gi++) begin : g_rot
    logic [SW-1:0] sum;
    assign sum           = {1'b0, prio_ptr} + SW'(gi);
    assign cand_idx[gi]  = (sum >= SW'(p_nreqs)) ? p_idx_nbits'(sum - SW'(p_nreqs))
                                                 : sum[p_idx_nbits-1:0];
    assign cand_val[gi]  = reqs[cand_idx[gi]];
  end

  assign any_req = |reqs;

  // Scan from the far end so the candidate closest to the pointer wins
  always_comb begin
    gnt_idx = '0;
    for (int k = p_nreqs - 1; k >= 0; k--) begin
      if (cand_val[k]) gnt_idx = cand_idx[k];
    end
  end

endmodule

// File: rtl/lab1_imul_mul_arbiter.sv
// Shares one iterative multiplier among p_nreqs requesters, one transaction
// in flight, round-robin issue and owner-steered responses.
module lab1_imul_mul_arbiter
  import lab1_imul_mul_arbiter_pkg::*;
#(
  parameter  int p_nreqs     = 4,
  localparam int p_idx_nbits = $clog2(p_nreqs)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [p_nreqs-1:0]             req_val,
  output logic [p_nreqs-1:0]             req_rdy,
  input  logic [p_nreqs*REQ_NBITS-1:0]   req_msg,
  output logic [p_nreqs-1:0]             resp_val,
  input  logic [p_nreqs-1:0]             resp_rdy,
  output logic [RESP_NBITS-1:0]          resp_msg,
  output logic                           mul_req_val,
  input  logic                           mul_req_rdy,
  output logic [REQ_NBITS-1:0]           mul_req_msg,
  input  logic                           mul_resp_val,
  output logic                           mul_resp_rdy,
  input  logic [RESP_NBITS-1:0]          mul_resp_msg
);

  arb_state_e             state_reg,    state_next;
  logic [p_idx_nbits-1:0] owner_reg,    owner_next;
  logic [p_idx_nbits-1:0] prio_ptr_reg, prio_ptr_next;

  logic [p_idx_nbits-1:0] gnt_idx;
  logic                   any_req;
  logic [REQ_NBITS-1:0]   req_msg_arr [p_nreqs];

  for (genvar gi = 0; gi < p_nreqs; gi++) begin : g_unpack
    assign req_msg_arr[gi] = req_msg[gi*REQ_NBITS +: REQ_NBITS];
  end

  lab1_imul_rr_grant #(.p_nreqs(p_nreqs)) u_grant (
    .reqs     (req_val),
    .prio_ptr (prio_ptr_reg),
    .gnt_idx  (gnt_idx),
    .any_req  (any_req)
  );

  assign mul_req_msg = req_msg_arr[gnt_idx];
  assign resp_msg    = mul_resp_msg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      owner_reg    <= '0;
      prio_ptr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      prio_ptr_reg <= prio_ptr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    prio_ptr_next = prio_ptr_reg;
    req_rdy       = '0;
    resp_val      = '0;
    mul_req_val   = 1'b0;
    mul_resp_rdy  = 1'b0;

    unique case (state_reg)
      IDLE: begin
        mul_req_val      = any_req;
        req_rdy[gnt_idx] = mul_req_rdy;
        if (any_req && mul_req_rdy) begin
          owner_next    = gnt_idx;
          prio_ptr_next = (gnt_idx == p_idx_nbits'(p_nreqs - 1)) ? '0 : gnt_idx + 1'b1;
          state_next    = WAIT;
        end
      end
      WAIT: begin
        resp_val[owner_reg] = mul_resp_val;
        mul_resp_rdy        = resp_rdy[owner_reg];
        if (mul_resp_val && resp_rdy[owner_reg]) state_next = IDLE;
      end
    endcase

    // Handshake outputs are held quiet for the whole reset cycle
    if (reset) begin
      req_rdy      = '0;
      resp_val     = '0;
      mul_req_val  = 1'b0;
      mul_resp_rdy = 1'b0;
    end
  end

endmodule

// File: tb/tb_lab1_imul_mul_arbiter.sv
// Bench for lab1_imul_mul_arbiter: grant table, directed corner sequences and
// a randomized run against a transaction-level arbiter model and multiplier.
module tb_lab1_imul_mul_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_val, req_rdy, resp_val, resp_rdy;
  logic [64*N-1:0] req_msg;
  logic [31:0]    resp_msg;
  logic           mul_req_val, mul_req_rdy, mul_resp_val, mul_resp_rdy;
  logic [63:0]    mul_req_msg;
  logic [31:0]    mul_resp_msg;

  always #5 clk = ~clk;

  lab1_imul_mul_arbiter #(.p_nreqs(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_val      (req_val),
    .req_rdy      (req_rdy),
    .req_msg      (req_msg),
    .resp_val     (resp_val),
    .resp_rdy     (resp_rdy),
    .resp_msg     (resp_msg),
    .mul_req_val  (mul_req_val),
    .mul_req_rdy  (mul_req_rdy),
    .mul_req_msg  (mul_req_msg),
    .mul_resp_val (mul_resp_val),
    .mul_resp_rdy (mul_resp_rdy),
    .mul_resp_msg (mul_resp_msg)
  );

  int total = 0;
  int bad   = 0;

  // multiplier environment
  bit          mul_busy;
  int          mul_cnt;
  logic [31:0] mul_res;
  bit          mul_stall;
  int          mul_lat;

  // arbiter reference model
  bit          m_busy;
  int          m_owner;
  int          m_ptr;
  logic [31:0] m_expect;

  int          issue_log[$];
  int          resp_port_log[$];
  logic [31:0] resp_data_log[$];

  typedef struct {
    int         pre;
    logic [N-1:0] vals;
    logic [N-1:0] gnt;
  } vec_t;
  vec_t tbl[9];

  function automatic int grant_of(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic send(input int port, input logic [31:0] a, input logic [31:0] b);
    req_msg[64*port +: 64] = {a, b};
    req_val[port] = 1'b1;
  endtask

  // One clock cycle: drive env, check DUT outputs, advance env/model.
  task automatic tick();
    logic [N-1:0] hs;
    logic [63:0]  gm;
    int g;
    mul_req_rdy  = !mul_busy && !mul_stall;
    mul_resp_val = mul_busy && (mul_cnt == 0);
    mul_resp_msg = mul_busy ? mul_res : 32'hdead_beef;
    #1;
    chk("resp_msg_pass", resp_msg, mul_resp_msg);
    if (reset) begin
      chk("rst_req_rdy", req_rdy, 0);
      chk("rst_resp_val", resp_val, 0);
      chk("rst_mul_req_val", mul_req_val, 0);
      chk("rst_mul_resp_rdy", mul_resp_rdy, 0);
    end else if (!m_busy) begin
      g = grant_of(req_val, m_ptr);
      chk("mul_req_val", mul_req_val, g >= 0);
      chk("idle_resp_val", resp_val, 0);
      chk("idle_mul_resp_rdy", mul_resp_rdy, 0);
      if (g >= 0) begin
        gm = req_msg[64*g +: 64];
        chk("req_rdy", req_rdy, mul_req_rdy ? onehot(g) : '0);
        chk("mul_req_msg", mul_req_msg, gm);
      end else begin
        chk("req_rdy_noreq", req_rdy & req_val, 0);
      end
    end else begin
      chk("wait_mul_req_val", mul_req_val, 0);
      chk("wait_req_rdy", req_rdy, 0);
      chk("resp_val", resp_val, mul_resp_val ? onehot(m_owner) : '0);
      chk("mul_resp_rdy", mul_resp_rdy, resp_rdy[m_owner]);
    end

    if (reset) mul_busy = 0;
    else if (!mul_busy) begin
      if (mul_req_val && mul_req_rdy) begin
        mul_busy = 1;
        mul_cnt  = mul_lat;
        mul_res  = mul_req_msg[63:32] * mul_req_msg[31:0];
      end
    end else if (mul_cnt > 0) mul_cnt--;
    else if (mul_resp_rdy) mul_busy = 0;

    hs = req_val & req_rdy;

    if (reset) begin
      m_busy = 0; m_ptr = 0; m_owner = 0;
    end else if (!m_busy) begin
      g = grant_of(req_val, m_ptr);
      if (g >= 0 && mul_req_rdy) begin
        gm       = req_msg[64*g +: 64];
        m_busy   = 1;
        m_owner  = g;
        m_ptr    = (g + 1) % N;
        m_expect = gm[63:32] * gm[31:0];
        issue_log.push_back(g);
        $display("issue port=%0d a=%0d b=%0d", g, gm[63:32], gm[31:0]);
      end
    end else if (mul_resp_val && resp_rdy[m_owner]) begin
      chk("resp_product", resp_msg, m_expect);
      m_busy = 0;
      resp_port_log.push_back(m_owner);
      resp_data_log.push_back(resp_msg);
      $display("resp  port=%0d prod=%0d", m_owner, resp_msg);
    end

    @(negedge clk);
    for (int i = 0; i < N; i++) if (hs[i]) req_val[i] = 1'b0;
  endtask

  task automatic clear_logs();
    issue_log.delete();
    resp_port_log.delete();
    resp_data_log.delete();
  endtask

  task automatic do_reset();
    req_val   = '0;
    resp_rdy  = '1;
    mul_stall = 0;
    clear_logs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while ((req_val != 0 || m_busy) && c < budget) begin
      tick();
      c++;
    end
    chk("drain_timeout", (req_val != 0) || m_busy, 0);
  endtask

  task automatic wait_issue(input int budget);
    int c;
    c = 0;
    while (!m_busy && c < budget) begin
      tick();
      c++;
    end
    chk("issue_timeout", m_busy, 1);
  endtask

  initial begin
    reset = 1'b1; req_val = '0; resp_rdy = '1; req_msg = '0;
    mul_req_rdy = 0; mul_resp_val = 0; mul_resp_msg = '0;
    mul_busy = 0; mul_cnt = 0; mul_res = '0; mul_stall = 0; mul_lat = 3;
    m_busy = 0; m_owner = 0; m_ptr = 0; m_expect = '0;

    tbl[0] = '{-1, 4'b0001, 4'b0001};
    tbl[1] = '{-1, 4'b1110, 4'b0010};
    tbl[2] = '{ 0, 4'b0001, 4'b0001};
    tbl[3] = '{ 0, 4'b1101, 4'b0100};
    tbl[4] = '{ 2, 4'b1010, 4'b1000};
    tbl[5] = '{ 3, 4'b1010, 4'b0010};
    tbl[6] = '{ 1, 4'b0011, 4'b0001};
    tbl[7] = '{ 3, 4'b1111, 4'b0001};
    tbl[8] = '{ 2, 4'b0100, 4'b0100};

    @(negedge clk);
    do_reset();

    // grant table: set the pointer with one transaction, then present a pattern
    for (int t = 0; t < 9; t++) begin
      do_reset();
      if (tbl[t].pre >= 0) begin
        send(tbl[t].pre, 32'd1, 32'd1);
        drain(50);
      end
      for (int i = 0; i < N; i++) if (tbl[t].vals[i]) send(i, 32'(i + 2), 32'd3);
      mul_req_rdy = 1'b1;
      #1;
      chk("tbl_gnt", req_rdy, tbl[t].gnt);
      drain(100);
    end

    // single requester on port 0
    do_reset();
    send(0, 32'd3, 32'd4);
    drain(50);
    chk("p0_nresp", resp_port_log.size(), 1);
    if (resp_port_log.size() == 1) begin
      chk("p0_port", resp_port_log[0], 0);
      chk("p0_prod", resp_data_log[0], 12);
    end

    // all four at once, then pointer back at 0
    do_reset();
    for (int i = 0; i < N; i++) send(i, 32'(i + 1), 32'd10);
    drain(200);
    chk("all_nissue", issue_log.size(), 4);
    if (issue_log.size() == 4)
      for (int i = 0; i < N; i++) begin
        chk("all_order", issue_log[i], i);
        chk("all_rport", resp_port_log[i], i);
        chk("all_prod", resp_data_log[i], 32'((i + 1) * 10));
      end
    clear_logs();
    send(3, 32'd2, 32'd2);
    send(0, 32'd2, 32'd3);
    drain(100);
    chk("ptr0_first", (issue_log.size() == 2) ? issue_log[0] : -1, 0);

    // pointer wrap: after port 2, ports 1 and 3 -> 3 then 1
    do_reset();
    send(2, 32'd1, 32'd1);
    drain(50);
    clear_logs();
    send(1, 32'd4, 32'd4);
    send(3, 32'd5, 32'd5);
    drain(100);
    chk("wrap_n", issue_log.size(), 2);
    if (issue_log.size() == 2) begin
      chk("wrap_first", issue_log[0], 3);
      chk("wrap_second", issue_log[1], 1);
    end

    // owner backpressure while a non-owner is ready
    do_reset();
    resp_rdy = 4'b1101;
    send(1, 32'd6, 32'd7);
    wait_issue(20);
    send(0, 32'd2, 32'd9);
    repeat (10) tick();
    chk("hold_nresp", resp_port_log.size(), 0);
    chk("hold_nissue", issue_log.size(), 1);
    chk("hold_mul_resp_rdy", mul_resp_rdy, 0);
    resp_rdy = '1;
    drain(100);
    chk("hold_n", resp_port_log.size(), 2);
    if (resp_port_log.size() == 2) begin
      chk("hold_port", resp_port_log[0], 1);
      chk("hold_prod", resp_data_log[0], 42);
      chk("hold_port2", resp_port_log[1], 0);
    end

    // reset during WAIT discards the in-flight result and zeroes the pointer
    do_reset();
    send(0, 32'd9, 32'd9);
    wait_issue(20);
    tick();
    clear_logs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    send(2, 32'd5, 32'd7);
    send(0, 32'd1, 32'd1);
    drain(100);
    chk("rst_n", issue_log.size(), 2);
    if (issue_log.size() == 2) begin
      chk("rst_first", issue_log[0], 0);
      chk("rst_port2", resp_port_log[1], 2);
      chk("rst_prod", resp_data_log[1], 35);
    end

    // multiplier not ready for five cycles
    do_reset();
    mul_stall = 1;
    send(1, 32'd8, 32'd8);
    repeat (5) tick();
    chk("stall_nissue", issue_log.size(), 0);
    mul_stall = 0;
    tick();
    chk("stall_issue", issue_log.size(), 1);
    drain(50);
    chk("stall_prod", (resp_data_log.size() == 1) ? resp_data_log[0] : 32'h0, 64);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++)
        if (!req_val[i] && $urandom_range(2) == 0) send(i, $urandom, $urandom);
      resp_rdy  = N'($urandom);
      mul_stall = ($urandom_range(3) == 0);
      mul_lat   = $urandom_range(4);
      tick();
    end
    resp_rdy  = '1;
    mul_stall = 0;
    drain(200);
    chk("rand_balance", issue_log.size(), resp_port_log.size());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/lab1_imul_mul_arbiter.md
# lab1_imul_mul_arbiter

Round-robin arbiter that shares one iterative integer multiplier (64-bit request {a,b}, 32-bit product response, val/rdy on both sides) among `p_nreqs` requesters. It sits between the requester ports and a single multiplier instance. It keeps at most one transaction in flight, records which port owns it, and steers the product back to that port only. The multiplier is instantiated by the enclosing top level, not inside this block.

## Interface
- `p_nreqs`, 4: number of requester ports (2..8).
- `p_idx_nbits`, $clog2(p_nreqs): owner/pointer width (derived, not overridden).
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset; one clock; all state is reset on the clock edge while high.
- `req_val`  in  p_nreqs  per-port request valid.
- `req_rdy`  out  p_nreqs  per-port request ready.
- `req_msg`  in  64*p_nreqs  port i occupies bits [64i+63:64i], {a[63:32], b[31:0]}.
- `resp_val`  out  p_nreqs  per-port response valid.
- `resp_rdy`  in  p_nreqs  per-port response ready.
- `resp_msg`  out  32  product, broadcast to all ports; qualified by `resp_val[i]`.
- `mul_req_val`/`mul_req_rdy`/`mul_req_msg`  out/in/out  1/1/64  request to multiplier.
- `mul_resp_val`/`mul_resp_rdy`/`mul_resp_msg`  in/out/in  1/1/32  response from multiplier.

## Operation
- States: IDLE (no transaction in flight), WAIT (one issued, awaiting response). Reset → IDLE.
- Registers: `state`, `owner[p_idx_nbits]`, `prio_ptr[p_idx_nbits]`. Reset value of each is IDLE/0/0.
- Grant, combinational: the first asserted `req_val[j]` scanning j = prio_ptr, prio_ptr+1, … mod p_nreqs. `gnt_idx` is its index, and `any_req` is the OR of `req_val`.
- IDLE:
  - `mul_req_val = any_req`; `mul_req_msg = req_msg[gnt_idx]`.
  - `req_rdy[gnt_idx] = mul_req_rdy`; every other `req_rdy` bit is 0.
  - `mul_resp_rdy = 0`; `resp_val = 0`.
- IDLE, on `mul_req_val && mul_req_rdy`:
  - `owner <= gnt_idx`
  - `prio_ptr <= (gnt_idx+1) mod p_nreqs`, wrapping from p_nreqs-1 to 0
  - state → WAIT
- WAIT:
  - `mul_req_val = 0`; `req_rdy = 0`.
  - `resp_val[owner] = mul_resp_val`; all other `resp_val` bits are 0.
  - `mul_resp_rdy = resp_rdy[owner]`; `resp_rdy` of non-owners is ignored.
  - `resp_msg = mul_resp_msg` in all states.
- WAIT, on `mul_resp_val && mul_resp_rdy`: state → IDLE. `prio_ptr` is unchanged.
- Ungranted ports wait. Their val must stay high and their msg stable until their own `req_rdy` fires. A port that drops val before being granted is simply skipped.
- No arithmetic is performed; all message data passes unmodified.

## Timing
- Zero added latency on both paths; all steering is combinational from registered state.
- Issue-to-response latency equals the multiplier's latency. The earliest next issue is the cycle after the response handshake, because the IDLE re-entry costs one cycle.
- While `reset` is high, all outputs are forced to 0: `req_rdy`, `resp_val`, `mul_req_val`, `mul_resp_rdy`. `resp_msg` follows `mul_resp_msg`.
- Reset mid-WAIT:
  - Return to IDLE with `owner` and `prio_ptr` at 0. The in-flight result is discarded.
  - The multiplier shares the same reset.
- Simultaneous requests: exactly one grant per IDLE handshake, in round-robin order.
- Backpressure:
  - `mul_req_rdy = 0` holds the IDLE state; no pointer update.
  - `resp_rdy[owner] = 0` holds WAIT indefinitely.
- Single requester: that port is granted every transaction; the pointer still advances past it.

## Structure
- Shared package `lab1_imul_mul_arbiter_pkg`: state encoding (IDLE=0, WAIT=1), request/response widths (64/32).
- One sub-module, `lab1_imul_rr_grant`:
  - Parameter p_nreqs.
  - Inputs: `reqs`, `prio_ptr`.
  - Outputs: `gnt_idx`, `any_req`.
  - Purely combinational.
- The FSM and steering muxes live in the top module.

## Test plan
- Port 0 only, msg {32'd3, 32'd4} → issued to multiplier. `resp_val` = 4'b0001 with `resp_msg` = 12; the other resp_val bits stay 0 throughout.
- All four ports valid at once with a=i+1, b=10 → issue order 0,1,2,3. Responses 10, 20, 30, 40 appear only on the matching port; `prio_ptr` returns to 0.
- After port 2 is served, ports 1 and 3 are both valid → port 3 granted first, then port 1 (pointer wrap).
- Owner port 1 holds `resp_rdy[1]=0` for 10 cycles while `resp_rdy[0]=1` → `mul_resp_rdy` stays 0 and no new `req_rdy` asserts. Release → one handshake, then IDLE.
- `reset` asserted for 1 cycle during WAIT → next cycle IDLE with pointer 0. A fresh request {5,7} on port 2 yields 35 on port 2.
- `mul_req_rdy` held 0 for 5 cycles with port 1 valid → `req_rdy[1]` is 0 during those cycles and the request issues on the first cycle `mul_req_rdy=1`.
